// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU types and widths
package alu_pkg;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ADC, OP_SBB} add_op_t;
  localparam int ALU_W = 32;
endpackage

// File: rtl/alu_add_pipe_carry_tree32.sv
// carry_tree32: 32-bit lookahead carry tree from two 16-bit prefix trees and a root cell
module carry_tree16 (
  output logic [15:0] c,
  output logic        gout,
  output logic        pout,
  input  logic        cin,
  input  logic [15:0] g,
  input  logic [15:0] p
);
  logic [15:0] gg, pp, ng, np;
  always_comb begin
    gg = g;
    pp = p;
    for (int k = 1; k < 16; k = k * 2) begin
      ng = gg;
      np = pp;
      for (int i = k; i < 16; i++) begin
        ng[i] = gg[i] | (pp[i] & gg[i-k]);
        np[i] = pp[i] & pp[i-k];
      end
      gg = ng;
      pp = np;
    end
    c = gg | (pp & {16{cin}});
    gout = gg[15];
    pout = pp[15];
  end
endmodule

module carry_tree32 (
  output logic [31:0] c,
  output logic        gout,
  output logic        pout,
  input  logic        Cin,
  input  logic [31:0] g,
  input  logic [31:0] p
);
  logic glo, plo, ghi, phi, c16;
  carry_tree16 u_lo (.c(c[15:0]), .gout(glo), .pout(plo), .cin(Cin), .g(g[15:0]), .p(p[15:0]));
  carry_tree16 u_hi (.c(c[31:16]), .gout(ghi), .pout(phi), .cin(c16), .g(g[31:16]), .p(p[31:16]));
  assign c16 = glo | (plo & Cin);
  assign gout = ghi | (phi & glo);
  assign pout = phi & plo;
endmodule

// File: rtl/alu_add_pipe.sv
// alu_add_pipe: two-stage pipelined 32-bit add/subtract with valid/ready handshakes
module alu_add_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n,
  output logic [TAG_W-1:0] out_tag
);
  add_op_t op;
  logic [WIDTH-1:0] b, g, p, c, sum;
  logic [TAG_W-1:0] tag;
  logic cin, ecin, s1_valid, s1_adv, s2_adv, unused_g, unused_p;
  assign op = add_op_t'(in_op);
  assign b = in_op[0] ? ~in_b : in_b;
  assign ecin = (op == OP_ADC || op == OP_SBB) ? in_cin : (op == OP_SUB);
  assign s2_adv = !out_valid | out_ready;
  assign s1_adv = !s1_valid | s2_adv;
  assign in_ready = s1_adv;
  carry_tree32 u_ct (.c(c), .gout(unused_g), .pout(unused_p), .Cin(cin), .g(g), .p(p));
  assign sum = p ^ {c[WIDTH-2:0], cin};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      g <= '0;
      p <= '0;
      cin <= 1'b0;
      tag <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        g <= in_a & b;
        p <= in_a ^ b;
        cin <= ecin;
        tag <= in_tag;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum <= '0;
      {out_c, out_v, out_z, out_n} <= 4'b0;
      out_tag <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum <= sum;
        out_c <= c[WIDTH-1];
        out_v <= c[WIDTH-1] ^ c[WIDTH-2];
        out_z <= (sum == '0);
        out_n <= sum[WIDTH-1];
        out_tag <= tag;
      end
    end
  end
endmodule

// File: tb/tb_alu_add_pipe.sv
// tb_alu_add_pipe: directed and randomized self-checking bench for alu_add_pipe
module tb_alu_add_pipe;
  logic clk = 0, rst_n, in_valid, in_ready, in_cin, out_valid, out_ready;
  logic out_c, out_v, out_z, out_n;
  logic [31:0] in_a, in_b, out_sum;
  logic [1:0] in_op;
  logic [3:0] in_tag, out_tag;
  int ncmp = 0, nfail = 0;
  logic [39:0] q[$];
  logic [39:0] held, got, want;
  logic hold_ok = 0;

  alu_add_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op, input logic ci);
    logic [31:0] bb;
    logic cc;
    logic [32:0] f;
    bb = op[0] ? ~b : b;
    cc = op[1] ? ci : op[0];
    f = {1'b0, a} + {1'b0, bb} + {32'b0, cc};
    return {f[31:0], f[32], (a[31] == bb[31]) && (f[31] != a[31]), f[31:0] == 32'b0, f[31]};
  endfunction

  // Scoreboard and output-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    got = {out_tag, out_sum, out_c, out_v, out_z, out_n};
    if (!rst_n) begin
      q.delete();
      hold_ok = 0;
    end else begin
      if (hold_ok && out_valid) chk("stable", {24'b0, got}, {24'b0, held});
      hold_ok = out_valid && !out_ready;
      held = got;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious", 64'd1, 64'd0);
        else begin
          want = q.pop_front();
          chk("sb", {24'b0, got}, {24'b0, want});
        end
      end
      if (in_valid && in_ready) q.push_back({in_tag, model(in_a, in_b, in_op, in_cin)});
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic ci, input logic [3:0] tg);
    in_a = a; in_b = b; in_op = op; in_cin = ci; in_tag = tg; in_valid = 1;
  endtask

  task automatic dir(input string nm, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] op, input logic ci, input logic [3:0] tg,
                     input logic [31:0] esum, input logic [3:0] ef);
    drive(a, b, op, ci, tg);
    chk({nm, " rdy"}, in_ready, 1);
    step;
    in_valid = 0;
    chk({nm, " lat1"}, out_valid, 0);
    step;
    chk({nm, " vld"}, out_valid, 1);
    chk({nm, " sum"}, out_sum, esum);
    chk({nm, " cvzn"}, {out_c, out_v, out_z, out_n}, ef);
    chk({nm, " tag"}, out_tag, tg);
    step;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 1;
    drive(0, 0, 0, 0, 0);
    in_valid = 0;
    step;
    chk("rst rdy", in_ready, 1);
    chk("rst vld", out_valid, 0);
    chk("rst sum", out_sum, 0);
    chk("rst cvzn", {out_c, out_v, out_z, out_n}, 0);
    chk("rst tag", out_tag, 0);
    step;
    rst_n = 1;
    step;
    dir("add ovf", 32'h7FFFFFFF, 32'h1, 2'd0, 1, 4'h1, 32'h80000000, 4'b0101);
    dir("sub eq", 32'h5, 32'h5, 2'd1, 0, 4'h2, 32'h0, 4'b1010);
    dir("sub neg", 32'h0, 32'h1, 2'd1, 0, 4'h3, 32'hFFFFFFFF, 4'b0001);
    dir("adc wrap", 32'hFFFFFFFF, 32'h0, 2'd2, 1, 4'h4, 32'h0, 4'b1010);
    dir("sbb", 32'd10, 32'd3, 2'd3, 0, 4'h5, 32'd6, 4'b1000);
    dir("add min", 32'h80000000, 32'h80000000, 2'd0, 0, 4'h6, 32'h0, 4'b1110);
    // back-to-back stream
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        drive(32'h1000 * i, i, 2'(i), i[0], 4'(i));
        chk("b2b rdy", in_ready, 1);
      end else in_valid = 0;
      if (i >= 2 && i < 10) begin
        chk("b2b vld", out_valid, 1);
        chk("b2b tag", out_tag, 4'(i - 2));
      end
      if (i == 10) chk("b2b end", out_valid, 0);
      step;
    end
    // backpressure
    out_ready = 0;
    drive(32'h11, 32'h22, 2'd0, 0, 4'h8);
    chk("bp rdy0", in_ready, 1);
    step;
    chk("bp rdy1", in_ready, 1);
    drive(32'h33, 32'h44, 2'd1, 0, 4'h9);
    step;
    drive(32'h55, 32'h66, 2'd2, 1, 4'hA);
    for (int i = 0; i < 3; i++) begin
      chk("bp full", in_ready, 0);
      chk("bp vld", out_valid, 1);
      chk("bp tag", out_tag, 4'h8);
      step;
    end
    out_ready = 1;
    #1;
    chk("bp release", in_ready, 1);
    step;
    in_valid = 0;
    chk("bp tag9", out_tag, 4'h9);
    step;
    chk("bp tagA", out_tag, 4'hA);
    step;
    chk("bp empty", out_valid, 0);
    // reset with ops in flight
    out_ready = 0;
    drive(32'h1, 32'h2, 2'd0, 0, 4'hC);
    step;
    drive(32'h3, 32'h4, 2'd0, 0, 4'hD);
    step;
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("mid rst vld", out_valid, 0);
    chk("mid rst rdy", in_ready, 1);
    chk("mid rst sum", out_sum, 0);
    step;
    step;
    rst_n = 1;
    out_ready = 1;
    step;
    chk("post rst vld", out_valid, 0);
    dir("post rst", 32'd100, 32'd58, 2'd1, 0, 4'hE, 32'd42, 4'b1000);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step;
    end
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 10 && q.size() != 0; i++) step;
    chk("drain", q.size(), 0);
    chk("final vld", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
